// File: rtl/bsg_demux_tagged_buffered.sv
// Tagged 1-to-N demultiplexer with a private 2-entry FIFO per output channel.
// One ready/valid input is steered by tag_i to one of els_p channels. A full
// channel only stalls words aimed at itself. A word with an out-of-range tag
// is accepted and dropped, and it sets a sticky error flag.
module bsg_demux_tagged_buffered #(
  parameter int width_p = 128,
  parameter int els_p = 4,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  input  logic [lg_els_lp-1:0]       tag_i,
  output logic                       ready_o,
  output logic [els_p-1:0]           valid_o,
  output logic [els_p*width_p-1:0]   data_o,
  input  logic [els_p-1:0]           yumi_i,
  output logic                       error_o
);

  // Word storage; it is never reset because valid_o qualifies it.
  logic [width_p-1:0] mem [els_p][2];

  logic [els_p-1:0] wptr;
  logic [els_p-1:0] rptr;
  logic [els_p-1:0] full;
  logic [els_p-1:0] empty;
  logic [els_p-1:0] enq;
  logic             legal;
  logic             ready_sel;
  logic             accept;

  // With one channel the tag is ignored and every word is routed to channel 0.
  function automatic logic tag_hit(input logic [lg_els_lp-1:0] tag, input int k);
    return (els_p == 1) || (32'(tag) == 32'(k));
  endfunction

  assign legal = (els_p == 1) || (32'(tag_i) < 32'(els_p));

  // Equal pointers mean either empty or full; the full flag decides which.
  assign empty   = ~full & ~(wptr ^ rptr);
  assign valid_o = ~empty;

  // Drive each channel's head word onto its slice of data_o.
  for (genvar k = 0; k < els_p; k++) begin : g_head
    assign data_o[k*width_p +: width_p] = mem[k][rptr[k]];
  end

  // Decide ready from the addressed channel only. An illegal tag matches no
  // channel, so ready stays 1 and the word is dropped.
  always_comb begin
    ready_sel = 1'b1;
    enq       = '0;
    for (int k = 0; k < els_p; k++) begin
      if (tag_hit(tag_i, k)) ready_sel = ~full[k];
    end
    ready_o = ~reset_i & ready_sel;
    accept  = valid_i & ready_o;
    for (int k = 0; k < els_p; k++) begin
      enq[k] = accept & tag_hit(tag_i, k);
    end
  end

  // Update the pointers, the full flags and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr    <= '0;
      rptr    <= '0;
      full    <= '0;
      error_o <= 1'b0;
    end else begin
      for (int k = 0; k < els_p; k++) begin
        if (enq[k]) wptr[k] <= ~wptr[k];
        if (yumi_i[k]) rptr[k] <= ~rptr[k];
        // Enqueue alone: an empty FIFO gets one entry, and a one-entry FIFO
        // becomes full. Dequeue alone always leaves room.
        if (enq[k] && !yumi_i[k]) full[k] <= ~empty[k];
        else if (yumi_i[k] && !enq[k]) full[k] <= 1'b0;
      end
      if (accept && !legal) error_o <= 1'b1;
    end
  end

  // Write accepted words into the addressed channel at its write pointer.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < els_p; k++) begin
      if (enq[k]) mem[k][wptr[k]] <= data_i;
    end
  end

  // A consumer may only dequeue a channel that shows a valid head.
  assert property (@(posedge clk_i) disable iff (reset_i) (yumi_i & ~valid_o) == '0);

endmodule
